// File: rtl/divisor_meter.sv
// divisor_meter: measures the period of a square wave on sig_i in clknexys_i
// cycles and reports the divider setting S that produces it, where a divider
// toggling at count S gives a period of 2*(S+1) clocks.
//   err_o: 00 ok, 01 timeout/overflow, 10 odd period.
// Optional build macro DIVMETER_AVG4_EN: average four consecutive periods
// (five rising edges) into one result instead of measuring a single period.
module divisor_meter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clknexys_i,
  input  logic             rstn_i,
  input  logic             sig_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] self_o,
  output logic [1:0]       err_o
);

  // Counter is wide enough for the ARM wait limit, so it never wraps.
  localparam int CW = WIDTH + 2;
  // Last counter values before the limit is reached; the limit itself is
  // the value loaded on the way to DONE.
  localparam logic [CW-1:0] ARM_LAST  = CW'((2 ** (WIDTH + 2)) - 2);
  localparam logic [CW-1:0] MEAS_LAST = CW'(2 ** (WIDTH + 1));

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_ODD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS,
    ST_DONE
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sig_edge;
  logic [CW-1:0]          cnt_q;
  logic [WIDTH-1:0]       res_self;
  logic                   res_odd;

`ifdef DIVMETER_AVG4_EN
  localparam int SW = WIDTH + 4;
  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_nxt;
  logic [1:0]    idx_q;
`endif

  // Synchronise the asynchronous input and keep one cycle of history.
  always_ff @(posedge clknexys_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the previous
      // value of its neighbour, which is what builds the shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Result of a completed measurement, taken from the count at the closing edge.
  always_comb begin
`ifdef DIVMETER_AVG4_EN
    sum_nxt  = sum_q + SW'(cnt_q);
    res_self = WIDTH'((sum_nxt >> 3) - SW'(1));
    res_odd  = |sum_nxt[2:0];
`else
    res_self = WIDTH'((cnt_q >> 1) - CW'(1));
    res_odd  = cnt_q[0];
`endif
  end

  // Measurement sequencer with registered status outputs.
  always_ff @(posedge clknexys_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      self_o  <= '0;
      err_o   <= ERR_OK;
`ifdef DIVMETER_AVG4_EN
      sum_q   <= '0;
      idx_q   <= '0;
`endif
    end else begin
      // NOTE: done_o defaults low every cycle so that the single assignment
      // on the way into DONE produces exactly a one-cycle pulse.
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_ARM;
            busy_o  <= 1'b1;
            cnt_q   <= '0;
`ifdef DIVMETER_AVG4_EN
            sum_q   <= '0;
            idx_q   <= '0;
`endif
          end
        end

        ST_ARM: begin
          // An edge takes priority over the wait limit in the same cycle.
          if (sig_edge) begin
            state_q <= ST_MEAS;
            cnt_q   <= CW'(1);
          end else if (cnt_q == ARM_LAST) begin
            state_q <= ST_DONE;
            cnt_q   <= cnt_q + CW'(1);
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            err_o   <= ERR_TMO;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_MEAS: begin
          if (sig_edge) begin
`ifdef DIVMETER_AVG4_EN
            if (idx_q != 2'd3) begin
              sum_q <= sum_nxt;
              idx_q <= idx_q + 2'd1;
              cnt_q <= CW'(1);
            end else begin
              state_q <= ST_DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              self_o  <= res_self;
              err_o   <= res_odd ? ERR_ODD : ERR_OK;
            end
`else
            state_q <= ST_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            self_o  <= res_self;
            err_o   <= res_odd ? ERR_ODD : ERR_OK;
`endif
          end else if (cnt_q == MEAS_LAST) begin
            state_q <= ST_DONE;
            cnt_q   <= cnt_q + CW'(1);
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            err_o   <= ERR_TMO;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
